// File: rtl/datapath_bird_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | datapath_bird_pkg : control codes, colours and datapath FSM states |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package datapath_bird_pkg;

  typedef logic [3:0] code_t;

  // Codes issued by the bird control FSM
  localparam code_t B_START   = 4'b0000;
  localparam code_t B_RAISING = 4'b0001;
  localparam code_t B_FALLING = 4'b0010;
  localparam code_t B_STOP    = 4'b0011;
  localparam code_t B_DRAW    = 4'b0100;
  localparam code_t B_DEL     = 4'b1111;
  localparam code_t B_UPDATE  = 4'b1110;

  localparam logic [2:0] BIRD_COLOUR = 3'b110;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ERASE = 2'b01,
    S_PAINT = 2'b10,
    S_WAIT  = 2'b11
  } dp_state_e;

  function automatic logic is_motion(input code_t c);
    return (c[3:2] == 2'b00);
  endfunction

  function automatic int coord_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/datapath_bird_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | datapath_bird_if : controller <-> bird datapath and pixel bus      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface datapath_bird_if;
  import datapath_bird_pkg::*;

  code_t      state_in;
  logic       press_key;
  logic       pipe_hit;
  logic       step;
  logic       flag;
  logic       touched;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output state_in, press_key, pipe_hit,
    input  step, flag, touched, x, y, colour, plot
  );

  modport slave (
    input  state_in, press_key, pipe_hit,
    output step, flag, touched, x, y, colour, plot
  );

endinterface

`default_nettype wire

// File: rtl/datapath_bird_sprite_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sprite_sweeper : raster-order SIZE x SIZE offset generator         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sprite_sweeper
  import datapath_bird_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int CW   = coord_w(SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  output logic [CW-1:0] cx_o,
  output logic [CW-1:0] cy_o,
  output logic          active_o,
  output logic          last_o
);

  localparam int            IW       = 2 * CW;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE * SIZE - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic          active_q, active_d;

  // idx names the pixel being emitted this cycle; start_i emits pixel 0
  always_comb begin
    idx_d    = idx_q;
    active_d = active_q;
    if (start_i || active_q) begin
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        active_d = 1'b0;
      end else begin
        idx_d    = idx_q + IW'(1);
        active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign cx_o     = idx_q[CW-1:0];
  assign cy_o     = idx_q[IW-1:CW];
  assign active_o = active_q;
  assign last_o   = (idx_q == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/datapath_bird.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | datapath_bird : erase / move / redraw datapath for the bird sprite |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module datapath_bird
  import datapath_bird_pkg::*;
#(
  parameter int X_POS       = 40,
  parameter int Y_START     = 60,
  parameter int SIZE        = 4,
  parameter int Y_TOP_LIMIT = 10,
  parameter int GROUND_Y    = 116,
  parameter int RISE_STEP   = 2,
  parameter int FALL_STEP   = 1
) (
  input  logic           clk,
  input  logic           reset,
  datapath_bird_if.slave dp_io
);

  localparam int         CW      = coord_w(SIZE);
  localparam logic [7:0] FLOOR_Y = 8'(GROUND_Y - SIZE);

  dp_state_e  state_q;
  logic [6:0] bird_y_q;
  code_t      mode_q;
  logic       step_q;
  logic       flag_q;
  logic       touched_q;
  logic       plot_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;

  logic [CW-1:0] sw_cx;
  logic [CW-1:0] sw_cy;
  logic          sw_active;
  logic          sw_last;

  logic       w_start;
  logic       w_sweep;
  logic       w_paint;
  logic [7:0] w_y_ext;
  logic [7:0] w_y_sum;
  logic [6:0] bird_y_d;

  assign w_start = (state_q == S_IDLE) &&
                   ((dp_io.state_in == B_DEL) || (dp_io.state_in == B_DRAW));
  assign w_sweep = w_start || sw_active;
  assign w_paint = (state_q == S_IDLE) ? (dp_io.state_in == B_DRAW)
                                       : (state_q == S_PAINT);

  sprite_sweeper #(
    .SIZE (SIZE),
    .CW   (CW)
  ) u_sweeper (
    .clk      (clk),
    .reset    (reset),
    .start_i  (w_start),
    .cx_o     (sw_cx),
    .cy_o     (sw_cy),
    .active_o (sw_active),
    .last_o   (sw_last)
  );

  // One bit of headroom so rising and falling saturate instead of wrapping
  assign w_y_ext = {1'b0, bird_y_q};
  assign w_y_sum = w_y_ext + 8'(FALL_STEP);

  always_comb begin
    bird_y_d = bird_y_q;
    case (mode_q)
      B_RAISING: bird_y_d = (w_y_ext >= 8'(RISE_STEP)) ? 7'(w_y_ext - 8'(RISE_STEP)) : 7'd0;
      B_FALLING: bird_y_d = (w_y_sum > FLOOR_Y) ? 7'(FLOOR_Y) : 7'(w_y_sum);
      B_START:   bird_y_d = 7'(Y_START);
      default:   bird_y_d = bird_y_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bird_y_q  <= 7'(Y_START);
      mode_q    <= B_START;
      step_q    <= 1'b0;
      flag_q    <= 1'b0;
      touched_q <= 1'b0;
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
    end else begin
      step_q    <= 1'b0;
      plot_q    <= w_sweep;
      flag_q    <= (bird_y_q <= 7'(Y_TOP_LIMIT));
      touched_q <= (mode_q == B_STOP) ? dp_io.press_key
                 : (dp_io.pipe_hit || ((w_y_ext + 8'(SIZE)) >= 8'(GROUND_Y)));
      if (w_sweep) begin
        x_q      <= 8'(X_POS) + 8'(sw_cx);
        y_q      <= bird_y_q + 7'(sw_cy);
        colour_q <= w_paint ? BIRD_COLOUR : BG_COLOUR;
      end
      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            if (sw_last) begin
              state_q <= S_WAIT;
              step_q  <= 1'b1;
            end else begin
              state_q <= (dp_io.state_in == B_DRAW) ? S_PAINT : S_ERASE;
            end
          end else begin
            // Single-cycle commands; unknown codes fall through to a bare step
            state_q <= S_WAIT;
            step_q  <= 1'b1;
            if (dp_io.state_in == B_UPDATE) begin
              bird_y_q <= bird_y_d;
            end else if (is_motion(dp_io.state_in)) begin
              mode_q <= dp_io.state_in;
            end
          end
        end
        S_ERASE, S_PAINT: begin
          if (sw_last) begin
            state_q <= S_WAIT;
            step_q  <= 1'b1;
          end
        end
        S_WAIT:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dp_io.step    = step_q;
  assign dp_io.flag    = flag_q;
  assign dp_io.touched = touched_q;
  assign dp_io.plot    = plot_q;
  assign dp_io.x       = x_q;
  assign dp_io.y       = y_q;
  assign dp_io.colour  = colour_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_bird.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_datapath_bird : directed bench with a command-level model       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_datapath_bird;

  localparam logic [3:0] C_START   = 4'b0000;
  localparam logic [3:0] C_RAISING = 4'b0001;
  localparam logic [3:0] C_FALLING = 4'b0010;
  localparam logic [3:0] C_STOP    = 4'b0011;
  localparam logic [3:0] C_DRAW    = 4'b0100;
  localparam logic [3:0] C_DEL     = 4'b1111;
  localparam logic [3:0] C_UPDATE  = 4'b1110;
  localparam logic [3:0] C_NOP     = 4'b0101;

  logic clk = 1'b0;
  logic reset;

  datapath_bird_if dp_if ();

  datapath_bird #(
    .X_POS       (40),
    .Y_START     (60),
    .SIZE        (4),
    .Y_TOP_LIMIT (10),
    .GROUND_Y    (116),
    .RISE_STEP   (2),
    .FALL_STEP   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dp_io (dp_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       plot;
    logic       step;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } pix_t;

  int         vectors     = 0;
  int         miscompares = 0;

  pix_t       q[$];
  pix_t       e_cur;
  pix_t       nxt;
  int         m_y;
  logic [3:0] m_mode;
  logic       m_wait;
  logic       m_live = 1'b0;
  logic       e_flag;
  logic       e_touch;
  logic       nf;
  logic       nt;

  // A command becomes the list of output cycles it must produce
  task automatic accept(input logic [3:0] c);
    pix_t p;
    p = '0;
    case (c)
      C_DEL, C_DRAW: begin
        for (int r = 0; r < 4; r++) begin
          for (int k = 0; k < 4; k++) begin
            p.plot = 1'b1;
            p.step = (r == 3) && (k == 3);
            p.x    = 8'(40 + k);
            p.y    = 7'(m_y + r);
            p.col  = (c == C_DRAW) ? 3'b110 : 3'b000;
            q.push_back(p);
          end
        end
      end
      C_UPDATE: begin
        if (m_mode == C_RAISING)      m_y = (m_y - 2 < 0) ? 0 : m_y - 2;
        else if (m_mode == C_FALLING) m_y = (m_y + 1 > 112) ? 112 : m_y + 1;
        else if (m_mode == C_START)   m_y = 60;
        p.step = 1'b1;
        q.push_back(p);
      end
      default: begin
        if (c == C_START || c == C_RAISING || c == C_FALLING || c == C_STOP) m_mode = c;
        p.step = 1'b1;
        q.push_back(p);
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset === 1'b1) begin
        m_y     = 60;
        m_mode  = C_START;
        q.delete();
        e_cur   = '0;
        e_flag  = 1'b0;
        e_touch = 1'b0;
        m_wait  = 1'b0;
        m_live  = 1'b1;
      end else if (m_live) begin
        nf = (m_y <= 10);
        nt = (m_mode == C_STOP) ? dp_if.press_key : (dp_if.pipe_hit || (m_y + 4 >= 116));
        if (q.size() == 0 && !m_wait) accept(dp_if.state_in);
        if (q.size() != 0) begin
          nxt = q.pop_front();
          if (!nxt.plot) begin
            nxt.x   = e_cur.x;
            nxt.y   = e_cur.y;
            nxt.col = e_cur.col;
          end
        end else begin
          nxt      = e_cur;
          nxt.plot = 1'b0;
          nxt.step = 1'b0;
        end
        m_wait  = nxt.step;
        e_cur   = nxt;
        e_flag  = nf;
        e_touch = nt;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        vectors++;
        if ({dp_if.plot, dp_if.step, dp_if.x, dp_if.y, dp_if.colour, dp_if.flag, dp_if.touched} !==
            {e_cur.plot, e_cur.step, e_cur.x, e_cur.y, e_cur.col, e_flag, e_touch}) begin
          miscompares++;
          $display("FAIL cycle_check @%0t: dut plot/step/x/y/col/flag/touched=%b/%b/%0d/%0d/%b/%b/%b required %b/%b/%0d/%0d/%b/%b/%b",
                   $time, dp_if.plot, dp_if.step, dp_if.x, dp_if.y, dp_if.colour, dp_if.flag, dp_if.touched,
                   e_cur.plot, e_cur.step, e_cur.x, e_cur.y, e_cur.col, e_flag, e_touch);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  int         g_plots;
  int         g_cycles;
  logic [7:0] g_fx;
  logic [7:0] g_lx;
  logic [6:0] g_fy;
  logic [6:0] g_ly;
  logic [2:0] g_lcol;

  // Acts as the controller: hold a code until step, then drop to a no-op code
  task automatic cmd(input logic [3:0] c);
    int n;
    dp_if.state_in = c;
    n       = 0;
    g_plots = 0;
    do begin
      @(negedge clk);
      n++;
      if (dp_if.plot === 1'b1) begin
        g_plots++;
        if (g_plots == 1) begin
          g_fx = dp_if.x;
          g_fy = dp_if.y;
        end
        g_lx   = dp_if.x;
        g_ly   = dp_if.y;
        g_lcol = dp_if.colour;
      end
    end while (dp_if.step !== 1'b1 && n < 40);
    g_cycles = n;
    if (dp_if.step !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL cmd_timeout: code %b got no step within %0d cycles", c, n);
    end
    dp_if.state_in = C_NOP;
  endtask

  int n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    dp_if.state_in  = C_NOP;
    dp_if.press_key = 1'b0;
    dp_if.pipe_hit  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_plot", dp_if.plot, 0);
    chk("rst_step", dp_if.step, 0);
    chk("rst_x", dp_if.x, 0);
    chk("rst_y", dp_if.y, 0);
    chk("rst_colour", dp_if.colour, 0);
    chk("rst_flag", dp_if.flag, 0);
    chk("rst_touched", dp_if.touched, 0);
    reset = 1'b0;

    // Erase sweep straight out of reset
    cmd(C_DEL);
    chk("del_plots", g_plots, 16);
    chk("del_step_cycle", g_cycles, 16);
    chk("del_first_x", g_fx, 40);
    chk("del_first_y", g_fy, 60);
    chk("del_last_x", g_lx, 43);
    chk("del_last_y", g_ly, 63);
    chk("del_colour", g_lcol, 0);

    // Fall one row
    cmd(C_FALLING);
    cmd(C_UPDATE);
    repeat (1) @(negedge clk);
    chk("fall_flag", dp_if.flag, 0);
    cmd(C_DRAW);
    chk("fall_draw_y", g_fy, 61);
    chk("draw_colour", g_lcol, 3'b110);
    cmd(C_NOP);

    // Rise to the top and saturate
    cmd(C_FALLING);
    cmd(C_UPDATE);
    cmd(C_RAISING);
    repeat (30) cmd(C_UPDATE);
    chk("model_y_at_2", m_y, 2);
    cmd(C_DRAW);
    chk("rise_draw_y2", g_fy, 2);
    chk("flag_at_2", dp_if.flag, 1);
    cmd(C_UPDATE);
    cmd(C_UPDATE);
    cmd(C_DRAW);
    chk("rise_sat_first_y", g_fy, 0);
    chk("rise_sat_last_y", g_ly, 3);
    chk("flag_at_0", dp_if.flag, 1);

    // Fall to the ground and saturate
    cmd(C_FALLING);
    repeat (110) cmd(C_UPDATE);
    @(negedge clk);
    chk("model_y_at_110", m_y, 110);
    chk("touched_at_110", dp_if.touched, 0);
    repeat (2) cmd(C_UPDATE);
    @(negedge clk);
    chk("touched_at_112", dp_if.touched, 1);
    repeat (3) cmd(C_UPDATE);
    cmd(C_DRAW);
    chk("ground_first_y", g_fy, 112);
    chk("ground_last_y", g_ly, 115);

    // Pipe collision at the start height
    cmd(C_START);
    cmd(C_UPDATE);
    @(negedge clk);
    chk("start_touched", dp_if.touched, 0);
    dp_if.pipe_hit = 1'b1;
    @(negedge clk);
    chk("pipe_touched", dp_if.touched, 1);
    dp_if.pipe_hit = 1'b0;
    @(negedge clk);
    chk("pipe_released", dp_if.touched, 0);

    // STOP: only the key matters
    cmd(C_FALLING);
    cmd(C_UPDATE);
    cmd(C_STOP);
    dp_if.pipe_hit = 1'b1;
    @(negedge clk);
    chk("stop_ignores_pipe", dp_if.touched, 0);
    dp_if.pipe_hit  = 1'b0;
    dp_if.press_key = 1'b1;
    @(negedge clk);
    chk("stop_key_touched", dp_if.touched, 1);
    dp_if.press_key = 1'b0;
    @(negedge clk);
    chk("stop_key_released", dp_if.touched, 0);
    cmd(C_UPDATE);
    cmd(C_DRAW);
    chk("stop_hold_y", g_fy, 61);
    cmd(C_START);
    cmd(C_UPDATE);
    cmd(C_DRAW);
    chk("restart_y", g_fy, 60);

    // Reset in the middle of a sweep
    cmd(C_FALLING);
    cmd(C_UPDATE);
    dp_if.state_in = C_DRAW;
    n       = 0;
    g_plots = 0;
    while (g_plots < 5 && n < 40) begin
      @(negedge clk);
      n++;
      if (dp_if.plot === 1'b1) g_plots++;
    end
    chk("abort_5th_pixel", g_plots, 5);
    reset          = 1'b1;
    dp_if.state_in = C_NOP;
    @(negedge clk);
    chk("abort_plot_low", dp_if.plot, 0);
    chk("abort_no_step", dp_if.step, 0);
    reset = 1'b0;
    cmd(C_DRAW);
    chk("abort_then_draw_y", g_fy, 60);
    chk("abort_then_draw_plots", g_plots, 16);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
